// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Misaligned-redirect handling is selected by the FETCH_MISALIGN_EN macro in fetch_unit.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [2:0]  MEM_WORD         = 3'b010;
    localparam int          FIFO_DEPTH       = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, word} buffer between instruction memory and the core.
// Slot 0 is always the head; clear wins over push and pop.
module fetch_fifo import fetch_pkg::*; (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count < 2'(FIFO_DEPTH)) || do_pop);
    assign head    = slot0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_entry;
                    else               slot1 <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-cycle memory, 2-entry instruction buffer, zero-cycle redirect.
// Define FETCH_MISALIGN_EN to halt on misaligned redirect targets instead of forcing alignment.
module fetch_unit import fetch_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_read_address,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_read_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        fetch_misaligned
`endif
);

    logic [31:0]  fetch_pc;
    logic [31:0]  inflight_pc;
    logic [31:0]  target_pc;
    logic         inflight;
    logic         discard;
    logic         take_redirect;
    logic         running;
    logic         pop;
    logic         push;
    logic         room;
    logic         issue;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t push_entry;

`ifdef FETCH_MISALIGN_EN
    fetch_state_e state;
    fetch_state_e state_next;

    assign target_pc = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        take_redirect = 1'b0;
        if (redirect_valid) begin
            if (redirect_pc[1:0] != 2'b00) begin
                state_next = ST_HALT;
            end else begin
                state_next    = ST_RUN;
                take_redirect = 1'b1;
            end
        end
    end

    assign running          = (state == ST_RUN);
    assign fetch_misaligned = (state == ST_HALT);
`else
    assign target_pc     = align_word(redirect_pc);
    assign take_redirect = redirect_valid;
    assign running       = 1'b1;
`endif

    assign mem_read_address = redirect_valid ? target_pc : fetch_pc;
    assign mem_funct3       = MEM_WORD;

    // Memory answers one edge after issue, so the word for any older request is on
    // mem_read_data at the redirect edge itself and is dropped right there.
    assign discard = redirect_valid;
    assign push    = inflight && !discard;
    assign pop     = instr_valid && instr_ready && !redirect_valid;

    // Occupancy after this edge (count + arriving word - pop) must stay below depth.
    assign room  = ({1'b0, count} + {2'b00, inflight}) < (3'(FIFO_DEPTH) + {2'b00, pop});
    assign issue = take_redirect || (running && room && !redirect_valid);

    assign push_entry = '{pc: inflight_pc, word: mem_read_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= mem_read_address;
                fetch_pc    <= mem_read_address + 32'd4;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    assign instr_valid = (count != 2'd0);
    assign instr       = head.word;
    assign instr_pc    = head.pc;

endmodule
